// File: rtl/seq_det_param_if.sv
// Bit-stream, pattern-control and match signals of the serial sequence detector.
// The master drives the stream and the pattern; the slave (detector) returns the match results.
interface seq_det_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             x;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, x, load, pat_in, overlap,
    input  out, match_cnt
  );

  modport slave (
    input  en, x, load, pat_in, overlap,
    output out, match_cnt
  );
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector with a run-time reloadable pattern and a registered
// one-cycle match pulse. The saturating match counter is built only when SEQDET_CNT_EN is defined.
module seq_det_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 'b1011,
  parameter int unsigned      CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  seq_det_param_if.slave bus
);

  localparam int unsigned FillW = $clog2(PAT_W);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_W - 2);

  typedef enum logic {StFill, StRun} state_e;

  state_e           state_q;
  logic [PAT_W-2:0] hist_q;
  logic [FillW-1:0] fill_q;
  logic [PAT_W-1:0] pat_q;
  logic             out_q;

  logic [PAT_W-1:0] shifted;
  logic             match;

  always_comb begin
    shifted = {hist_q, bus.x};
    match   = (state_q == StRun) && bus.en && (shifted == pat_q);
  end

  // load outranks en; the bit presented on a load edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
      out_q   <= 1'b0;
    end else if (bus.load) begin
      state_q <= StFill;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= bus.pat_in;
      out_q   <= 1'b0;
    end else if (bus.en) begin
      out_q <= match;
      unique case (state_q)
        StFill: begin
          hist_q <= shifted[PAT_W-2:0];
          fill_q <= fill_q + FillW'(1);
          if (fill_q == FillLast) state_q <= StRun;
        end
        StRun: begin
          if (match && !bus.overlap) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= StFill;
          end else begin
            hist_q <= shifted[PAT_W-2:0];
          end
        end
      endcase
    end else begin
      out_q <= 1'b0;
    end
  end

  assign bus.out = out_q;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.load) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a queue-based model of the received bit window is checked
// against the DUT every cycle, with literal expectations pinning the scripted cases.
module tb_seq_det_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_det_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_det_param #(
    .PAT_W  (PAT_W),
    .PAT_RST(4'b1011),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the last valid bits since the last restart, oldest first.
  bit               mq[$];
  logic [PAT_W-1:0] mpat = 4'b1011;
  logic             exp_out = 1'b0;
  int               exp_cnt = 0;
  logic             last_out;
  int               pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_expect(input int c);
`ifdef SEQDET_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear(input logic [PAT_W-1:0] p);
    mq.delete();
    mpat    = p;
    exp_out = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_edge();
    logic [PAT_W-1:0] w;
    bit               m;
    if (bus.load) begin
      model_clear(bus.pat_in);
    end else if (bus.en) begin
      mq.push_back(bus.x);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      m = 1'b0;
      if (mq.size() == PAT_W) begin
        for (int i = 0; i < PAT_W; i++) w[PAT_W-1-i] = mq[i];
        m = (w == mpat);
      end
      exp_out = m;
      if (m) begin
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        if (!bus.overlap) mq.delete();
      end
    end else begin
      exp_out = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic b, input logic ld);
    @(negedge clk);
    bus.en   = e;
    bus.x    = b;
    bus.load = ld;
    @(posedge clk);
    model_edge();
    #1;
    last_out = bus.out;
    if (last_out) pulses++;
  endtask

  task automatic load_pat(input logic [PAT_W-1:0] p, input logic b);
    bus.pat_in = p;
    step(1'b1, b, 1'b1);
    bus.load = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("out_vs_model", {31'd0, bus.out}, {31'd0, exp_out});
    chk("cnt_vs_model", {30'd0, bus.match_cnt}, cnt_expect(exp_cnt));
  end

  logic [6:0] s7;
  logic [5:0] lit6;
  logic [6:0] lit7;
  logic [15:0] s16;

  initial begin
    bus.en = 1'b0; bus.x = 1'b0; bus.load = 1'b0; bus.pat_in = '0; bus.overlap = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out", {31'd0, bus.out}, 0);
    chk("reset_cnt", {30'd0, bus.match_cnt}, 0);
    #2 rst = 1'b0;

    // T1: overlapping 1011 on 1011011
    s7 = 7'b1011011; lit7 = 7'b0001001; bus.overlap = 1'b1;
    load_pat(4'b1011, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s7[i], 1'b0);
      chk("T1_out", {31'd0, last_out}, {31'd0, lit7[i]});
    end

    // T2: non-overlapping, same stream
    lit7 = 7'b0001000; bus.overlap = 1'b0;
    load_pat(4'b1011, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s7[i], 1'b0);
      chk("T2_out", {31'd0, last_out}, {31'd0, lit7[i]});
    end

    // T3: 1011 spread over idle cycles with x toggling
    bus.overlap = 1'b1;
    load_pat(4'b1011, 1'b0);
    pulses = 0;
    s7 = 7'b0001011;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, s7[i], 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, k[0], 1'b0);
    end
    chk("T3_pulses", pulses, 1);

    // T4: all-zero pattern, x=1 on load edge ignored
    lit6 = 6'b000111;
    load_pat(4'b0000, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, 1'b0, 1'b0);
      chk("T4_out", {31'd0, last_out}, {31'd0, lit6[i]});
    end
    chk("T4_cnt", {30'd0, bus.match_cnt}, cnt_expect(3));
    // Reset while the pulse is high: out must fall without a clock edge.
    #1 rst = 1'b1;
    model_clear(4'b1011);
    #1 chk("async_rst_out", {31'd0, bus.out}, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // T5: partial 101 lost to reset, then a full 1011
    pulses = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    model_clear(4'b1011);
    @(negedge clk);
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("T5_no_early", pulses, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("T5_pulse", {31'd0, last_out}, 1);

    // T6: five overlapping matches saturate a 2-bit counter; load clears it
    s16 = 16'b1011011011011011;
    load_pat(4'b1011, 1'b0);
    pulses = 0;
    for (int i = 15; i >= 0; i--) step(1'b1, s16[i], 1'b0);
    chk("T6_pulses", pulses, 5);
    chk("T6_sat", {30'd0, bus.match_cnt}, cnt_expect(3));
    load_pat(4'b1011, 1'b0);
    chk("T6_load_clr", {30'd0, bus.match_cnt}, 0);

    // Overlap switched mid-stream applies at the next match
    pulses = 0;
    bus.overlap = 1'b1;
    for (int i = 6; i >= 4; i--) step(1'b1, s7[i], 1'b0);
    bus.overlap = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 2; i >= 0; i--) step(1'b1, s16[i], 1'b0);
    chk("ovl_switch_pulses", pulses, 1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
